// File: rtl/fft_stream_checker.sv
// fft_stream_checker: synthesizable scoreboard for multi-lane FFT result beats.
// Every accepted beat is compared lane-by-lane against a golden row within a
// +/-TOL modular window. Error, pass, missing, overrun and timeout are reported
// so that the same checker serves on-chip self-test and simulation.
module fft_stream_checker #(
    parameter int LANES      = 16,
    parameter int DW         = 16,
    parameter int TOL        = 3,
    parameter int FRAMES     = 64,
    parameter int INTERLEAVE = 1,
    parameter int TIMEOUT    = 100000,
    parameter int AW         = $clog2(FRAMES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  dut_valid,
    input  logic [LANES*DW-1:0]   dut_d,
    input  logic                  dut_done,
    output logic                  gold_rd,
    output logic [AW-1:0]         gold_addr,
    input  logic [LANES*DW-1:0]   gold_re,
    input  logic [LANES*DW-1:0]   gold_im,
    output logic                  busy,
    output logic                  finished,
    output logic                  pass,
    output logic                  beat_err,
    output logic [15:0]           err_cnt,
    output logic [15:0]           ok_cnt,
    output logic [AW-1:0]         first_err_addr,
    output logic                  first_err_imag,
    output logic                  missing,
    output logic                  overrun,
    output logic                  timeout
);
    localparam int E   = FRAMES * (1 + INTERLEAVE);   // expected beats per run
    localparam int BW  = $clog2(E + 1);
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam int CW  = $clog2(LANES + 1);
    localparam logic signed [DW-1:0] TOL_P = DW'(TOL);
    localparam logic signed [DW-1:0] TOL_N = DW'(-TOL);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t              r_state;
    logic                r_busy, r_finished, r_pass, r_missing, r_overrun, r_timeout;
    logic [WDW-1:0]      r_wd;
    logic [BW-1:0]       r_beats;
    logic [AW-1:0]       r_f;
    logic                r_ph;
    logic                r_drain;

    logic                r_s1_vld;
    logic [LANES*DW-1:0] r_s1_d;
    logic [AW-1:0]       r_s1_f;
    logic                r_s1_ph;

    logic                r_beat_err;
    logic [15:0]         r_err_cnt, r_ok_cnt;
    logic [AW-1:0]       r_first_addr;
    logic                r_first_imag;

    logic                w_accept;
    logic                w_start;
    logic [LANES*DW-1:0] w_gold_row;
    logic signed [DW-1:0] w_diff;
    logic [CW-1:0]       w_fail_cnt, w_ok_cnt;

    // A beat is accepted only while running and before the expected count is reached.
    assign w_accept  = (r_state == S_RUN) && dut_valid && (r_beats < BW'(E));
    assign w_start   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign gold_rd   = w_accept;
    assign gold_addr = r_f;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [CW-1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + 17'(b);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Run-control FSM with beat index, watchdog and registered status flags.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_finished <= 1'b0;
            r_pass     <= 1'b0;
            r_missing  <= 1'b0;
            r_overrun  <= 1'b0;
            r_timeout  <= 1'b0;
            r_wd       <= '0;
            r_beats    <= '0;
            r_f        <= '0;
            r_ph       <= 1'b0;
            r_drain    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start) begin
                        r_state    <= S_RUN;
                        r_busy     <= 1'b1;
                        r_finished <= 1'b0;
                        r_pass     <= 1'b0;
                        r_missing  <= 1'b0;
                        r_overrun  <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_wd       <= '0;
                        r_beats    <= '0;
                        r_f        <= '0;
                        r_ph       <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_beats <= r_beats + BW'(1);
                        if ((INTERLEAVE != 0) && !r_ph) begin
                            r_ph <= 1'b1;
                        end else begin
                            r_ph <= 1'b0;
                            r_f  <= r_f + AW'(1);
                        end
                    end
                    if (dut_valid && (r_beats == BW'(E))) r_overrun <= 1'b1;
                    r_wd <= r_wd + WDW'(1);
                    if (dut_done) begin
                        r_state <= S_DRAIN;
                        r_drain <= 1'b0;
                    end else if (r_wd == WDW'(TIMEOUT - 1)) begin
                        r_state    <= S_DONE;
                        r_busy     <= 1'b0;
                        r_finished <= 1'b1;
                        r_timeout  <= 1'b1;
                        r_missing  <= 1'b0;
                        r_pass     <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    // Two flush cycles let the last compare reach the counters.
                    if (r_drain) begin
                        r_state    <= S_DONE;
                        r_busy     <= 1'b0;
                        r_finished <= 1'b1;
                        r_missing  <= (r_beats < BW'(E));
                        r_pass     <= (r_err_cnt == 16'd0) && (r_beats == BW'(E)) && !r_overrun;
                    end else begin
                        r_drain <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Stage 1: capture the accepted beat with its frame/phase tags while the golden row is read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_s1_d   <= '0;
            r_s1_f   <= '0;
            r_s1_ph  <= 1'b0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1_d  <= dut_d;
                r_s1_f  <= r_f;
                r_s1_ph <= r_ph;
            end
        end
    end

    // Per-lane modular window compare against the golden row now on gold_re/gold_im.
    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        w_fail_cnt = '0;
        w_ok_cnt   = '0;
        w_diff     = '0;
        w_gold_row = r_s1_ph ? gold_im : gold_re;
        for (int i = 0; i < LANES; i++) begin
            w_diff = w_gold_row[i*DW +: DW] - r_s1_d[i*DW +: DW];
            // An unknown lane makes the condition unknown and falls to the failing branch.
            if ((w_diff >= TOL_N) && (w_diff <= TOL_P)) w_ok_cnt = w_ok_cnt + CW'(1);
            else                                        w_fail_cnt = w_fail_cnt + CW'(1);
        end
    end

    // Stage 2: error pulse, saturating lane counters and first-error capture.
    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_beat_err   <= 1'b0;
            r_err_cnt    <= '0;
            r_ok_cnt     <= '0;
            r_first_addr <= '0;
            r_first_imag <= 1'b0;
        end else begin
            r_beat_err <= r_s1_vld && (w_fail_cnt != '0);
            if (r_s1_vld) begin
                r_err_cnt <= sat_add(r_err_cnt, w_fail_cnt);
                r_ok_cnt  <= sat_add(r_ok_cnt, w_ok_cnt);
                if ((w_fail_cnt != '0) && (r_err_cnt == 16'd0)) begin
                    r_first_addr <= r_s1_f;
                    r_first_imag <= r_s1_ph;
                end
            end
        end
    end

    assign busy           = r_busy;
    assign finished       = r_finished;
    assign pass           = r_pass;
    assign beat_err       = r_beat_err;
    assign err_cnt        = r_err_cnt;
    assign ok_cnt         = r_ok_cnt;
    assign first_err_addr = r_first_addr;
    assign first_err_imag = r_first_imag;
    assign missing        = r_missing;
    assign overrun        = r_overrun;
    assign timeout        = r_timeout;

endmodule

// File: tb/tb_fft_stream_checker.sv
// Bench for fft_stream_checker: directed runs with randomized golden data and
// perturbations, checked against a beat-level model of the scoreboard rules.
module tb_fft_stream_checker;
    localparam int LANES  = 16;
    localparam int DW     = 16;
    localparam int TOL    = 3;
    localparam int FRAMES = 64;
    localparam int E      = FRAMES * 2;
    localparam int TMO    = 5000;
    localparam int AW     = 6;

    logic                clk = 1'b0;
    logic                rst, start, dut_valid, dut_done;
    logic [LANES*DW-1:0] dut_d, gold_re, gold_im;
    logic                gold_rd, busy, finished, pass, beat_err;
    logic [AW-1:0]       gold_addr, first_err_addr;
    logic [15:0]         err_cnt, ok_cnt;
    logic                first_err_imag, missing, overrun, timeout;

    fft_stream_checker #(.LANES(LANES), .DW(DW), .TOL(TOL), .FRAMES(FRAMES),
                         .INTERLEAVE(1), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .dut_valid(dut_valid), .dut_d(dut_d),
        .dut_done(dut_done), .gold_rd(gold_rd), .gold_addr(gold_addr),
        .gold_re(gold_re), .gold_im(gold_im), .busy(busy), .finished(finished),
        .pass(pass), .beat_err(beat_err), .err_cnt(err_cnt), .ok_cnt(ok_cnt),
        .first_err_addr(first_err_addr), .first_err_imag(first_err_imag),
        .missing(missing), .overrun(overrun), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Golden data indexed by beat number (2*frame + phase) and the stream the FFT would emit.
    logic [15:0] gold_mem [E][LANES];
    logic [15:0] dut_mem  [E][LANES];

    // Synchronous golden ROM: row appears one cycle after the read.
    always @(posedge clk) begin
        if (gold_rd) begin
            for (int i = 0; i < LANES; i++) begin
                gold_re[i*DW +: DW] <= gold_mem[2*gold_addr][i];
                gold_im[i*DW +: DW] <= gold_mem[2*gold_addr+1][i];
            end
        end
    end

    int n_cmp = 0, n_fail = 0, cyc = 0;
    bit m_run, m_have_err, m_overrun, m_timeout, be_pipe;
    int m_beats, m_ok, m_err, m_first_addr, m_first_imag, m_start_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit lane_ok(input logic [15:0] g, input logic [15:0] d);
        int x;
        x = (int'(g) - int'(d) + 65536) % 65536;
        if (x >= 32768) x -= 65536;
        return (x >= -TOL) && (x <= TOL);
    endfunction

    // One clock cycle: drive, check the read strobe, update the model, check the error pulse.
    task automatic send(input bit v, input int bidx, input bit dn);
        logic [LANES*DW-1:0] w;
        bit bad;
        int nbad;
        w = '0;
        bad = 1'b0;
        if (v) for (int i = 0; i < LANES; i++) w[i*DW +: DW] = dut_mem[bidx][i];
        dut_valid = v;
        dut_d     = w;
        dut_done  = dn;
        #1;
        check("gold_rd", gold_rd, v && m_run && (m_beats < E));
        if (v && m_run && (m_beats < E)) check("gold_addr", gold_addr, m_beats / 2);
        if (!rst && m_run) begin
            if (v) begin
                if (m_beats < E) begin
                    nbad = 0;
                    for (int i = 0; i < LANES; i++) begin
                        if (lane_ok(gold_mem[m_beats][i], w[i*DW +: DW])) m_ok++;
                        else nbad++;
                    end
                    if (nbad > 0) begin
                        bad = 1'b1;
                        m_err += nbad;
                        if (!m_have_err) begin
                            m_have_err   = 1'b1;
                            m_first_addr = m_beats / 2;
                            m_first_imag = m_beats % 2;
                        end
                    end
                    m_beats++;
                end else begin
                    m_overrun = 1'b1;
                end
            end
            if (dn) m_run = 1'b0;
        end else if (!rst && start) begin
            m_run = 1'b1; m_have_err = 1'b0; m_overrun = 1'b0; m_timeout = 1'b0;
            m_beats = 0; m_ok = 0; m_err = 0; m_first_addr = 0; m_first_imag = 0;
            m_start_cyc = cyc + 1;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (m_run && (cyc - m_start_cyc == TMO)) begin
            m_run = 1'b0;
            m_timeout = 1'b1;
        end
        check("beat_err", beat_err, rst ? 1'b0 : be_pipe);
        be_pipe = rst ? 1'b0 : bad;
        dut_valid = 1'b0;
        dut_done  = 1'b0;
        dut_d     = '0;
    endtask

    task automatic do_start();
        start = 1'b1;
        send(1'b0, 0, 1'b0);
        start = 1'b0;
        check("start.busy", busy, 1'b1);
    endtask

    task automatic stream(input int first, input int n, input int gap_pct);
        for (int b = first; b < first + n; b++) begin
            if ($urandom_range(0, 99) < gap_pct) repeat ($urandom_range(1, 3)) send(1'b0, 0, 1'b0);
            send(1'b1, b, 1'b0);
        end
    endtask

    task automatic new_data();
        for (int b = 0; b < E; b++)
            for (int i = 0; i < LANES; i++) begin
                gold_mem[b][i] = 16'($urandom);
                dut_mem[b][i]  = gold_mem[b][i];
            end
    endtask

    // done (optionally with a last beat), then finished must rise exactly two edges later.
    task automatic finish_run(input bit last_beat, input int bidx);
        send(last_beat, bidx, 1'b1);
        check("drain0.finished", finished, 1'b0);
        check("drain0.busy", busy, 1'b1);
        send(1'b0, 0, 1'b0);
        check("drain1.finished", finished, 1'b0);
        send(1'b0, 0, 1'b0);
        check("drain2.finished", finished, 1'b1);
    endtask

    task automatic check_end(input string tag);
        check({tag, ".finished"}, finished, 1'b1);
        check({tag, ".busy"}, busy, 1'b0);
        check({tag, ".timeout"}, timeout, m_timeout);
        check({tag, ".missing"}, missing, (m_beats < E) && !m_timeout);
        check({tag, ".overrun"}, overrun, m_overrun);
        check({tag, ".pass"}, pass, !m_have_err && (m_beats == E) && !m_overrun && !m_timeout);
        check({tag, ".err_cnt"}, err_cnt, m_err);
        check({tag, ".ok_cnt"}, ok_cnt, m_ok);
        check({tag, ".first_err_addr"}, first_err_addr, m_first_addr);
        check({tag, ".first_err_imag"}, first_err_imag, m_first_imag);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".busy"}, busy, 1'b0);
        check({tag, ".finished"}, finished, 1'b0);
        check({tag, ".pass"}, pass, 1'b0);
        check({tag, ".beat_err"}, beat_err, 1'b0);
        check({tag, ".err_cnt"}, err_cnt, 0);
        check({tag, ".ok_cnt"}, ok_cnt, 0);
        check({tag, ".first_err"}, {first_err_addr, first_err_imag}, 0);
        check({tag, ".flags"}, {missing, overrun, timeout}, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dut_valid = 1'b0; dut_done = 1'b0; dut_d = '0;
        m_run = 1'b0; be_pipe = 1'b0;
        send(1'b0, 0, 1'b0);
        send(1'b0, 0, 1'b0);
        rst = 1'b0;
        check_zero("reset");

        // Clean back-to-back run of all 128 beats, then done.
        new_data();
        do_start();
        stream(0, E, 0);
        finish_run(1'b0, 0);
        check_end("clean");
        check("clean.ok_const", ok_cnt, 2048);
        check("clean.pass_const", pass, 1'b1);

        // Frame 3 real, lane 5 off by +3: still inside the window.
        new_data();
        dut_mem[6][5] = gold_mem[6][5] + 16'd3;
        do_start();
        stream(0, E, 0);
        finish_run(1'b0, 0);
        check_end("tol3");
        check("tol3.pass_const", pass, 1'b1);

        // Same lane off by +4: one failing lane, first error at frame 3 real.
        dut_mem[6][5] = gold_mem[6][5] + 16'd4;
        do_start();
        stream(0, E, 0);
        finish_run(1'b0, 0);
        check_end("tol4");
        check("tol4.err_const", err_cnt, 1);
        check("tol4.addr_const", first_err_addr, 3);
        check("tol4.imag_const", first_err_imag, 1'b0);

        // Modular wrap-around cases.
        new_data();
        gold_mem[0][0] = 16'h0001; dut_mem[0][0] = 16'hFFFF;
        gold_mem[1][1] = 16'h8000; dut_mem[1][1] = 16'h7FFE;
        gold_mem[2][2] = 16'h0000; dut_mem[2][2] = 16'h8000;
        do_start();
        stream(0, E, 10);
        finish_run(1'b0, 0);
        check_end("wrap");
        check("wrap.err_const", err_cnt, 1);
        check("wrap.addr_const", first_err_addr, 1);

        // Random perturbations and gaps; done arrives together with the last beat.
        new_data();
        for (int b = 0; b < E; b++)
            for (int i = 0; i < LANES; i++)
                if ($urandom_range(0, 9) == 0)
                    dut_mem[b][i] = gold_mem[b][i] - 16'(int'($urandom_range(0, 12)) - 6);
        do_start();
        stream(0, E - 1, 30);
        finish_run(1'b1, E - 1);
        check_end("random");

        // Early done after 100 beats.
        new_data();
        do_start();
        stream(0, 100, 20);
        finish_run(1'b0, 0);
        check_end("missing");
        check("missing.ok_const", ok_cnt, 1600);
        check("missing.flag_const", missing, 1'b1);

        // A 129th beat before done.
        do_start();
        stream(0, E, 0);
        send(1'b1, 0, 1'b0);
        finish_run(1'b0, 0);
        check_end("overrun");
        check("overrun.flag_const", overrun, 1'b1);
        check("overrun.ok_const", ok_cnt, 2048);

        // Watchdog: no done; finished exactly TMO cycles after start.
        do_start();
        stream(0, 10, 0);
        while (cyc - m_start_cyc < TMO - 1) send(1'b0, 0, 1'b0);
        check("wd.before", finished, 1'b0);
        send(1'b0, 0, 1'b0);
        check("wd.at", finished, 1'b1);
        check("wd.timeout_const", timeout, 1'b1);
        check_end("timeout");

        // Reset at beat 40 aborts the run.
        new_data();
        do_start();
        stream(0, 40, 0);
        rst = 1'b1;
        send(1'b1, 40, 1'b0);
        rst = 1'b0;
        m_run = 1'b0;
        be_pipe = 1'b0;
        check_zero("midreset");

        // Fresh run with a stray start in RUN that must be ignored.
        do_start();
        stream(0, 20, 0);
        start = 1'b1;
        send(1'b1, 20, 1'b0);
        start = 1'b0;
        stream(21, E - 21, 10);
        finish_run(1'b0, 0);
        check_end("after_reset");
        check("after_reset.pass_const", pass, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
